enigma_stream_cipher: RTL and testbench

- Sequential, parametrised successor to the fixed four-box letter mapper: a true rotor-stepping Enigma core that encrypts an ASCII character stream.
- Each accepted letter steps the rotor stack, then passes forward through NUM_ROTORS rotors, a reflector, and back again. Encryption and decryption are the same operation when started from the same rotor positions.
- Sits between a character source and sink, with valid/ready handshakes on both sides and a runtime-loadable start position.

---
 rtl/enigma_pkg.sv | 78 +++++++
 rtl/enigma_rotor_stage.sv | 27 ++
 rtl/enigma_stream_cipher.sv | 166 ++++++++++++++++
 tb/tb_enigma_stream_cipher.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants for the Enigma stream cipher: rotor/reflector tables, notches,
// rotor order, FSM state type and the mod-26 helpers used by the rotor datapath.
package enigma_pkg;

  localparam int ALPHA = 26;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    REFL = 3'd2,
    BWD  = 3'd3,
    OUT  = 3'd4
  } state_e;

  localparam logic [8*26-1:0] ROTOR_I_STR   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*26-1:0] ROTOR_II_STR  = "AJDKSIRUXBLHWTMCQGZNPYVOEF";
  localparam logic [8*26-1:0] ROTOR_III_STR = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [8*26-1:0] ROTOR_IV_STR  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [8*26-1:0] ROTOR_V_STR   = "VZBRGITYUPSDNHLXAWMJQOFECK";

  localparam logic [4:0] WIRING [5][26] = '{
    '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9},
    '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd21, 5'd14, 5'd4, 5'd5},
    '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14},
    '{5'd4, 5'd18, 5'd14, 5'd21, 5'd15, 5'd25, 5'd9, 5'd0, 5'd24, 5'd16, 5'd20, 5'd8, 5'd17,
      5'd7, 5'd23, 5'd11, 5'd13, 5'd5, 5'd19, 5'd6, 5'd10, 5'd3, 5'd2, 5'd12, 5'd22, 5'd1},
    '{5'd21, 5'd25, 5'd1, 5'd17, 5'd6, 5'd8, 5'd19, 5'd24, 5'd20, 5'd15, 5'd18, 5'd3, 5'd13,
      5'd7, 5'd11, 5'd23, 5'd0, 5'd22, 5'd12, 5'd9, 5'd16, 5'd14, 5'd5, 5'd4, 5'd2, 5'd10}
  };

  localparam logic [4:0] INV_WIRING [5][26] = '{
    '{5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
      5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9},
    '{5'd0, 5'd9, 5'd15, 5'd2, 5'd24, 5'd25, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
      5'd19, 5'd23, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd22, 5'd12, 5'd8, 5'd21, 5'd18},
    '{5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
      5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12},
    '{5'd7, 5'd25, 5'd22, 5'd21, 5'd0, 5'd17, 5'd19, 5'd13, 5'd11, 5'd6, 5'd20, 5'd15, 5'd23,
      5'd16, 5'd2, 5'd4, 5'd9, 5'd12, 5'd1, 5'd18, 5'd10, 5'd3, 5'd24, 5'd14, 5'd8, 5'd5},
    '{5'd16, 5'd2, 5'd24, 5'd11, 5'd23, 5'd22, 5'd4, 5'd13, 5'd5, 5'd19, 5'd25, 5'd14, 5'd18,
      5'd12, 5'd21, 5'd9, 5'd20, 5'd3, 5'd10, 5'd6, 5'd8, 5'd0, 5'd17, 5'd15, 5'd7, 5'd1}
  };

  // UKW-B
  localparam logic [4:0] REFLECTOR [26] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19
  };

  localparam logic [4:0] NOTCH [5] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};
  localparam logic [2:0] ORDER [5] = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd4};

  function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ALPHA)) begin
      s = s - 6'(ALPHA);
    end else begin
      s = s;
    end
    return s[4:0];
  endfunction

  function automatic logic [4:0] mod26_sub(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) begin
      s = s + 6'(ALPHA);
    end else begin
      s = s;
    end
    return s[4:0];
  endfunction

endpackage

// File: rtl/enigma_rotor_stage.sv
// One rotor pass (forward or inverse), compensated for the rotor's rotation offset.
// Time-shared by the core across all FWD and BWD cycles.
module enigma_rotor_stage
  import enigma_pkg::*;
(
  input  logic [4:0] idx_i,
  input  logic [4:0] pos_i,
  input  logic [2:0] rotor_id_i,
  input  logic       dir_i,
  output logic [4:0] idx_out_o
);

  logic [4:0] entry_s;
  logic [4:0] mapped_s;

  // Rotate into the rotor frame, look up, rotate back out.
  always_comb begin
    entry_s = mod26_add(idx_i, pos_i);
    if (dir_i) begin
      mapped_s = INV_WIRING[rotor_id_i][entry_s];
    end else begin
      mapped_s = WIRING[rotor_id_i][entry_s];
    end
    idx_out_o = mod26_sub(mapped_s, pos_i);
  end

endmodule

// File: rtl/enigma_stream_cipher.sv
// Rotor-stepping Enigma core on a valid/ready character stream: one rotor per cycle
// forward, reflector, one rotor per cycle back, then hold the result until taken.
module enigma_stream_cipher
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter int CHAR_W     = 8,
  parameter int POS_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_load,
  input  logic [NUM_ROTORS*POS_W-1:0]  cfg_pos,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHAR_W-1:0]            in_char,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHAR_W-1:0]            out_char,
  output logic [NUM_ROTORS*POS_W-1:0]  pos_q,
  output logic                         busy
);

  localparam int         PW     = NUM_ROTORS * POS_W;
  localparam logic [2:0] LAST_K = 3'(NUM_ROTORS - 1);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [4:0]        idx_q, idx_d;
  logic [PW-1:0]     pos_d;
  logic [CHAR_W-1:0] out_char_q, out_char_d;

  logic [CHAR_W-1:0] upper_s;
  logic              is_letter_s;
  logic [4:0]        in_idx_s;
  logic [PW-1:0]     step_pos_s, load_pos_s;
  logic [4:0]        stage_pos_s, stage_idx_s;
  logic [2:0]        stage_rotor_s;
  logic              stage_bwd_s;

  // Fold lower case onto upper case and classify the incoming character.
  always_comb begin
    if (in_char >= CHAR_W'(8'h61) && in_char <= CHAR_W'(8'h7A)) begin
      upper_s = in_char - CHAR_W'(8'h20);
    end else begin
      upper_s = in_char;
    end
    is_letter_s = (upper_s >= CHAR_W'(8'h41)) && (upper_s <= CHAR_W'(8'h5A));
    in_idx_s    = 5'(upper_s - CHAR_W'(8'h41));
  end

  // Odometer stepping from pre-step positions, and clamped start positions.
  always_comb begin
    logic       adv;
    logic [4:0] cur, lim;
    adv        = 1'b1;
    step_pos_s = pos_q;
    load_pos_s = cfg_pos;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      cur = pos_q[k*POS_W +: POS_W];
      if (adv) begin
        step_pos_s[k*POS_W +: POS_W] = (cur == 5'd25) ? 5'd0 : cur + 5'd1;
      end else begin
        step_pos_s[k*POS_W +: POS_W] = cur;
      end
      adv = adv & (cur == NOTCH[ORDER[k]]);
      lim = cfg_pos[k*POS_W +: POS_W];
      load_pos_s[k*POS_W +: POS_W] = (lim > 5'd25) ? 5'd25 : lim;
    end
  end

  assign stage_pos_s   = pos_q[int'(k_q)*POS_W +: POS_W];
  assign stage_rotor_s = ORDER[k_q];
  assign stage_bwd_s   = (state_q == BWD);

  enigma_rotor_stage u_stage (
    .idx_i      (idx_q),
    .pos_i      (stage_pos_s),
    .rotor_id_i (stage_rotor_s),
    .dir_i      (stage_bwd_s),
    .idx_out_o  (stage_idx_s)
  );

  // Next-state logic; cfg_load outranks a character offered in the same IDLE cycle.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    idx_d      = idx_q;
    pos_d      = pos_q;
    out_char_d = out_char_q;
    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          pos_d = load_pos_s;
        end else if (in_valid) begin
          if (is_letter_s) begin
            pos_d   = step_pos_s;
            idx_d   = in_idx_s;
            k_d     = 3'd0;
            state_d = FWD;
          end else begin
            out_char_d = in_char;
            state_d    = OUT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FWD: begin
        idx_d = stage_idx_s;
        if (k_q == LAST_K) begin
          state_d = REFL;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      REFL: begin
        idx_d   = REFLECTOR[idx_q];
        k_d     = LAST_K;
        state_d = BWD;
      end
      BWD: begin
        idx_d = stage_idx_s;
        if (k_q == 3'd0) begin
          out_char_d = CHAR_W'(stage_idx_s) + CHAR_W'(8'h41);
          state_d    = OUT;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any character in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= 3'd0;
      idx_q      <= 5'd0;
      pos_q      <= '0;
      out_char_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      out_char_q <= out_char_d;
    end
  end

  assign in_ready  = rst_n & (state_q == IDLE) & ~cfg_load;
  assign out_valid = (state_q == OUT);
  assign out_char  = out_char_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_enigma_stream_cipher.sv
// Self-checking bench for enigma_stream_cipher: constant vector table, a string-based
// reference model feeding a scoreboard queue, and hand-written multi-cycle corner cases.
module tb_enigma_stream_cipher;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n, cfg_load, in_valid, in_ready, out_valid, out_ready, busy;
  logic [N*5-1:0] cfg_pos, pos_q;
  logic [7:0]    in_char, out_char;

  always #5 clk = ~clk;

  enigma_stream_cipher #(.NUM_ROTORS(N), .CHAR_W(8), .POS_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pos(cfg_pos),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .pos_q(pos_q), .busy(busy)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  string      rot_w [5];
  string      refl_w;
  string      notch_w;
  int         order [5];
  int         mpos [N];

  typedef struct {
    logic [14:0] start;
    string       in_s;
    string       exp_s;
    logic [14:0] end_pos;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] mpack();
    return {5'(mpos[2]), 5'(mpos[1]), 5'(mpos[0])};
  endfunction

  function automatic bit is_letter(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  // Reference Enigma: steps the model positions, then encrypts via the wiring strings.
  function automatic logic [7:0] model_enc(input logic [7:0] c);
    logic [7:0] up;
    int idx, p, t, prev, jhit;
    bit adv, nadv;
    string w;
    up = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    if (up < 8'h41 || up > 8'h5A) return c;
    adv = 1'b1;
    for (int k = 0; k < N; k++) begin
      prev = mpos[k];
      nadv = adv && (prev == int'(notch_w[order[k]]) - 65);
      if (adv) mpos[k] = (prev + 1) % 26;
      adv = nadv;
    end
    idx = int'(up) - 65;
    for (int k = 0; k < N; k++) begin
      p = mpos[k];
      w = rot_w[order[k]];
      t = int'(w[(idx + p) % 26]) - 65;
      idx = (t - p + 26) % 26;
    end
    idx = int'(refl_w[idx]) - 65;
    for (int k = N - 1; k >= 0; k--) begin
      p = mpos[k];
      w = rot_w[order[k]];
      t = (idx + p) % 26;
      jhit = 0;
      for (int j = 0; j < 26; j++) if (int'(w[j]) - 65 == t) jhit = j;
      idx = (jhit - p + 26) % 26;
    end
    return 8'(idx + 65);
  endfunction

  // Scoreboard: every completed output handshake pops one expected character.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h, expected none", out_char);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_char !== mon_exp) begin
          errors++;
          $display("FAIL out_char: got %h, expected %h", out_char, mon_exp);
        end
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1, expected 0 within 100 cycles");
    end
  endtask

  task automatic load(input logic [14:0] p);
    logic [4:0] v;
    wait_idle();
    cfg_load = 1'b1;
    cfg_pos  = p;
    @(posedge clk);
    #1 cfg_load = 1'b0;
    for (int k = 0; k < N; k++) begin
      v = p[k*5 +: 5];
      mpos[k] = (v > 5'd25) ? 25 : int'(v);
    end
  endtask

  // Offer one character; expected result is either the given constant or the model's.
  task automatic send(input logic [7:0] c, input logic [7:0] exp, input bit use_model,
                      input string name);
    logic [7:0] e;
    int lat;
    wait_idle();
    chk({name, " in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    e = model_enc(c);
    exp_q.push_back(use_model ? e : exp);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    // letters: 2N+1 edges after the accept edge; non-letters: visible right after it
    chk({name, " latency"}, lat, is_letter(c) ? 2 * N + 1 : 0);
    chk({name, " pos"}, pos_q, mpack());
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    string      s, x;
    rot_w[0] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    rot_w[1] = "AJDKSIRUXBLHWTMCQGZNPYVOEF";
    rot_w[2] = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    rot_w[3] = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
    rot_w[4] = "VZBRGITYUPSDNHLXAWMJQOFECK";
    refl_w   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    notch_w  = "QEVJZ";
    order    = '{2, 1, 0, 3, 4};
    for (int k = 0; k < N; k++) mpos[k] = 0;

    vecs[0] = '{15'd0, "AAAAA", "BDZGO", 15'd5};
    vecs[1] = '{15'd0, "BDZGO", "AAAAA", 15'd5};
    vecs[2] = '{15'd0, "aaaaa", "BDZGO", 15'd5};
    vecs[3] = '{15'd0, "A 7A",  "B 7D",  15'd2};

    rst_n = 1'b0; cfg_load = 1'b0; cfg_pos = '0; in_valid = 1'b0;
    in_char = 8'h00; out_ready = 1'b1;
    #12;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_char", out_char, 0);
    chk("rst busy", busy, 0);
    chk("rst pos", pos_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("idle in_ready", in_ready, 1);

    for (int v = 0; v < 4; v++) begin
      load(vecs[v].start);
      s = vecs[v].in_s;
      x = vecs[v].exp_s;
      for (int i = 0; i < s.len(); i++) begin
        send(8'(s[i]), 8'(x[i]), 1'b0, $sformatf("vec%0d[%0d]", v, i));
      end
      wait_idle();
      chk($sformatf("vec%0d end_pos", v), pos_q, vecs[v].end_pos);
    end

    load({5'd0, 5'd0, 5'd21});
    send("A", 8'h00, 1'b1, "notch");
    chk("notch carry pos", pos_q, {5'd0, 5'd1, 5'd22});
    load({5'd0, 5'd0, 5'd25});
    send("A", 8'h00, 1'b1, "wrap");
    chk("wrap no carry pos", pos_q, 15'd0);
    load({5'd0, 5'd4, 5'd0});
    send("A", 8'h00, 1'b1, "no_double");
    chk("no double step pos", pos_q, {5'd0, 5'd4, 5'd1});
    load({5'd0, 5'd30, 5'd31});
    chk("clamp pos", pos_q, {5'd0, 5'd25, 5'd25});

    load({5'd0, 5'd3, 5'd18});
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       send(8'($urandom_range(65, 90)), 8'h00, 1'b1, "rnd_uc");
        1:       send(8'($urandom_range(97, 122)), 8'h00, 1'b1, "rnd_lc");
        default: send(8'($urandom_range(48, 57)), 8'h00, 1'b1, "rnd_digit");
      endcase
    end

    load(15'd0);
    wait_idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_char   = "A";
    @(posedge clk);
    exp_q.push_back(model_enc("A"));
    #1 in_valid = 1'b0;
    begin
      int g = 0;
      while (!out_valid && g < 50) begin
        @(posedge clk);
        #1;
        g++;
      end
    end
    held = out_char;
    chk("hold first char", held, "B");
    for (int i = 0; i < 10; i++) begin
      cfg_pos  = {5'd9, 5'd9, 5'd9};
      cfg_load = (i == 5);
      @(posedge clk);
      #1;
      chk($sformatf("hold[%0d] valid/char/ready", i), {out_valid, out_char, in_ready},
          {1'b1, held, 1'b0});
    end
    cfg_load = 1'b0;
    chk("hold cfg_load ignored", pos_q, mpack());
    out_ready = 1'b1;

    wait_idle();
    cfg_load = 1'b1;
    cfg_pos  = {5'd0, 5'd0, 5'd7};
    in_valid = 1'b1;
    in_char  = "A";
    #1 chk("load+valid in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    mpos[0] = 7; mpos[1] = 0; mpos[2] = 0;
    chk("load wins pos", pos_q, 15'd7);
    chk("load wins busy", busy, 0);
    repeat (10) @(posedge clk);
    #1 chk("load wins no output", out_valid, 0);

    wait_idle();
    in_valid = 1'b1;
    in_char  = "A";
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst pos", pos_q, 0);
    chk("async rst busy", busy, 0);
    chk("async rst in_ready", in_ready, 0);
    for (int k = 0; k < N; k++) mpos[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send("A", "B", 1'b0, "after_rst");

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
